// File: rtl/fwd_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: operand select
// encodings, register address width and the pipeline stage records.
package fwd_ctrl_pkg;

    localparam int REG_AW = 4;

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } ex_rec_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } mem_rec_t;

    localparam ex_rec_t  EX_BUBBLE  = '0;
    localparam mem_rec_t MEM_BUBBLE = '0;

    // A stage only produces a forwardable value when it really writes a
    // non-zero register; R0 always reads as zero.
    function automatic logic tag_qualified(input logic              valid,
                                           input logic              regwrite,
                                           input logic [REG_AW-1:0] rd);
        return valid & regwrite & (rd != '0);
    endfunction

endpackage

// File: rtl/fwd_ctrl_sel.sv
// fwd_sel: compares one source register against the qualified EX and MEM
// destination tags and returns the operand mux select (EX/MEM wins).
module fwd_sel
    import fwd_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              ex_tag_vld,
    input  logic [REG_AW-1:0] ex_tag,
    input  logic              mem_tag_vld,
    input  logic [REG_AW-1:0] mem_tag,
    output logic [1:0]        sel
);

    always_comb begin
        sel = SEL_RF;
        if (ex_tag_vld && (ex_tag == src)) begin
            sel = SEL_EXMEM;
        end else if (mem_tag_vld && (mem_tag == src)) begin
            sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: tracks EX/MEM destination tags, registers the EX operand selects
// for the instruction in ID, and inserts one-cycle load-use bubbles.
module fwd_ctrl #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    import fwd_ctrl_pkg::*;

    ex_rec_t          ex_q, ex_d;
    mem_rec_t         mem_q, mem_d;
    logic [1:0]       src_a_q, src_a_d;
    logic [1:0]       src_b_q, src_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ex_tag_vld;
    logic             mem_tag_vld;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             load_use;
    logic             stall_int;

    assign ex_tag_vld  = tag_qualified(ex_q.valid, ex_q.regwrite, ex_q.rd);
    assign mem_tag_vld = tag_qualified(mem_q.valid, mem_q.regwrite, mem_q.rd);

    fwd_sel u_sel_a (
        .src         (id_rs1),
        .ex_tag_vld  (ex_tag_vld),
        .ex_tag      (ex_q.rd),
        .mem_tag_vld (mem_tag_vld),
        .mem_tag     (mem_q.rd),
        .sel         (sel_a)
    );

    fwd_sel u_sel_b (
        .src         (id_rs2),
        .ex_tag_vld  (ex_tag_vld),
        .ex_tag      (ex_q.rd),
        .mem_tag_vld (mem_tag_vld),
        .mem_tag     (mem_q.rd),
        .sel         (sel_b)
    );

    // A load in EX cannot forward to ID in time; hold ID one cycle so the
    // load reaches MEM. A taken branch kills ID anyway, so it wins.
    always_comb begin
        load_use  = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                    ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
        stall_int = load_use & ~flush;
    end

    always_comb begin
        ex_d    = EX_BUBBLE;
        src_a_d = SEL_RF;
        src_b_d = SEL_RF;
        mem_d   = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
        cnt_d   = cnt_q;

        if (!stall_int && !flush) begin
            ex_d.valid    = id_valid;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite & id_valid;
            ex_d.memread  = id_memread & id_valid;
            if (id_valid) begin
                src_a_d = sel_a;
                src_b_d = sel_b;
            end
        end

        if (stall_int && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= EX_BUBBLE;
            mem_q   <= MEM_BUBBLE;
            src_a_q <= SEL_RF;
            src_b_q <= SEL_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall     = stall_int;
    assign alu_src_a = src_a_q;
    assign alu_src_b = src_b_q;
    assign ex_valid  = ex_q.valid;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed hazard scenarios followed by
// randomized traffic checked against an instruction-history reference model.
module tb_fwd_ctrl;

    localparam int REG_AW = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic              stall;
    logic [1:0]        alu_src_a;
    logic [1:0]        alu_src_b;
    logic              ex_valid;
    logic [CNT_W-1:0]  stall_cnt;

    fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .ex_valid    (ex_valid),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the last two instructions that entered EX, newest
    // first (bubbles included), plus the expected stall count.
    typedef struct {
        bit       valid;
        bit       wr;
        bit       ld;
        bit [3:0] rd;
    } slot_t;

    slot_t h1, h2;
    int    exp_cnt;
    int    exp_a, exp_b;
    bit    exp_stall;
    bit    model_known = 1'b0;
    logic  last_stall_obs;
    int    checks = 0;
    int    failures = 0;

    function automatic bit writes(input slot_t s, input bit [3:0] src);
        return s.valid && s.wr && (s.rd != 0) && (s.rd == src);
    endfunction

    function automatic int sel_for(input bit [3:0] src);
        if (writes(h1, src)) return 1;
        if (writes(h2, src)) return 2;
        return 0;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkVal("alu_src_a", {30'd0, alu_src_a}, exp_a);
        checkVal("alu_src_b", {30'd0, alu_src_b}, exp_b);
        checkVal("ex_valid", {31'd0, ex_valid}, {31'd0, h1.valid});
        checkVal("stall_cnt", {28'd0, stall_cnt}, exp_cnt);
    endtask

    task automatic modelReset();
        h1 = '{default: 0};
        h2 = '{default: 0};
        exp_cnt = 0;
        exp_a = 0;
        exp_b = 0;
        model_known = 1'b1;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            id_valid    = 1'($urandom);
            id_rs1      = 4'($urandom);
            id_rs2      = 4'($urandom);
            id_rd       = 4'($urandom);
            id_regwrite = 1'($urandom);
            id_memread  = 1'($urandom);
            flush       = 1'($urandom);
            @(posedge clk);
            #1;
            modelReset();
            checkOutput();
            checkVal("reset_stall", {31'd0, stall}, 0);
        end
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input bit v, input bit [3:0] rs1, input bit [3:0] rs2,
                                 input bit [3:0] rd, input bit rw, input bit mr, input bit fl);
        slot_t nxt;
        int    sa, sb;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;
        #1;
        exp_stall = v && !fl && h1.valid && h1.ld && (h1.rd != 0) &&
                    ((h1.rd == rs1) || (h1.rd == rs2));
        last_stall_obs = stall;
        if (model_known) checkVal("stall", {31'd0, stall}, {31'd0, exp_stall});
        sa = 0;
        sb = 0;
        if (v && !exp_stall && !fl) begin
            sa = sel_for(rs1);
            sb = sel_for(rs2);
        end
        if (exp_stall || fl) nxt = '{default: 0};
        else nxt = '{valid: v, wr: rw && v, ld: mr && v, rd: rd};
        @(posedge clk);
        #1;
        h2 = h1;
        h1 = nxt;
        exp_a = sa;
        exp_b = sb;
        if (exp_stall && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        checkOutput();
    endtask

    initial begin
        bit       v, rw, mr, fl;
        bit [3:0] rs1, rs2, rd;

        $display("[TB] start");
        rst = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_regwrite = 0; id_memread = 0; flush = 0;

        doReset(3);

        // ALU chain: ADD R3; SUB R6 <- R3, R4
        applyStimulus(1, 4'd1, 4'd2, 4'd3, 1, 0, 0);
        applyStimulus(1, 4'd3, 4'd4, 4'd6, 1, 0, 0);
        checkVal("chain_a", {30'd0, alu_src_a}, 1);
        checkVal("chain_b", {30'd0, alu_src_b}, 0);

        // Distance two: ADD R3; NOP; use R3 on both operands
        applyStimulus(1, 4'd1, 4'd2, 4'd3, 1, 0, 0);
        applyStimulus(0, 4'd3, 4'd3, 4'd3, 1, 1, 0);
        applyStimulus(1, 4'd3, 4'd3, 4'd7, 1, 0, 0);
        checkVal("dist2_a", {30'd0, alu_src_a}, 2);
        checkVal("dist2_b", {30'd0, alu_src_b}, 2);

        // Priority: ADD R3; ADD R3; use R3
        applyStimulus(1, 4'd1, 4'd2, 4'd3, 1, 0, 0);
        applyStimulus(1, 4'd1, 4'd2, 4'd3, 1, 0, 0);
        applyStimulus(1, 4'd3, 4'd9, 4'd8, 1, 0, 0);
        checkVal("prio_a", {30'd0, alu_src_a}, 1);

        // Load-use: LW R5; ADD R8 <- R2, R5 (held one cycle)
        doReset(1);
        applyStimulus(1, 4'd1, 4'd0, 4'd5, 1, 1, 0);
        applyStimulus(1, 4'd2, 4'd5, 4'd8, 1, 0, 0);
        checkVal("lu_stall", {31'd0, last_stall_obs}, 1);
        checkVal("lu_bubble", {31'd0, ex_valid}, 0);
        applyStimulus(1, 4'd2, 4'd5, 4'd8, 1, 0, 0);
        checkVal("lu_nostall", {31'd0, last_stall_obs}, 0);
        checkVal("lu_src_b", {30'd0, alu_src_b}, 2);
        checkVal("lu_cnt", {28'd0, stall_cnt}, 1);

        // R0 is never forwarded
        applyStimulus(1, 4'd1, 4'd2, 4'd0, 1, 0, 0);
        applyStimulus(1, 4'd0, 4'd0, 4'd4, 1, 0, 0);
        checkVal("r0_a", {30'd0, alu_src_a}, 0);
        checkVal("r0_b", {30'd0, alu_src_b}, 0);

        // Flush overrides load-use
        applyStimulus(1, 4'd1, 4'd0, 4'd5, 1, 1, 0);
        applyStimulus(1, 4'd2, 4'd5, 4'd8, 1, 0, 1);
        checkVal("flush_stall", {31'd0, last_stall_obs}, 0);
        checkVal("flush_bubble", {31'd0, ex_valid}, 0);

        // Saturation: 19 load-use pairs with a 4-bit counter
        doReset(1);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            applyStimulus(1, 4'd1, 4'd0, 4'd5, 1, 1, 0);
            applyStimulus(1, 4'd2, 4'd5, 4'd8, 1, 0, 0);
            applyStimulus(1, 4'd2, 4'd5, 4'd8, 1, 0, 0);
        end
        checkVal("sat_cnt", {28'd0, stall_cnt}, 15);

        // Randomized traffic; a stalled consumer is re-presented unchanged
        doReset(2);
        v = 0; rs1 = 0; rs2 = 0; rd = 0; rw = 0; mr = 0; fl = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                doReset(1);
                exp_stall = 0;
            end
            if (!exp_stall) begin
                v   = ($urandom_range(0, 9) != 0);
                rs1 = 4'($urandom_range(0, 7));
                rs2 = 4'($urandom_range(0, 7));
                rd  = 4'($urandom_range(0, 7));
                rw  = ($urandom_range(0, 4) != 0);
                mr  = ($urandom_range(0, 2) == 0);
                fl  = ($urandom_range(0, 11) == 0);
            end else begin
                fl  = ($urandom_range(0, 11) == 0);
            end
            applyStimulus(v, rs1, rs2, rd, rw, mr, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
